// File: rtl/memory_stage_pkg.sv
// rtl/memory_stage_pkg.sv - shared encodings, bundle offsets and FSM types for the memory stage
package memory_stage_pkg;

  localparam logic [1:0] MEMOP_READ  = 2'b01;
  localparam logic [1:0] MEMOP_WRITE = 2'b10;
  localparam logic [1:0] SPOP_PUSH   = 2'b01;
  localparam logic [1:0] SPOP_POP    = 2'b10;

  // EX/MEM bundle offsets; [75:44] is the reserved SP field
  localparam int RSRC_VAL_HI  = 43;
  localparam int RSRC_VAL_LO  = 28;
  localparam int ALU_HI       = 27;
  localparam int ALU_LO       = 12;
  localparam int RSRC_ADDR_HI = 11;
  localparam int RSRC_ADDR_LO = 9;
  localparam int RDST_HI      = 8;
  localparam int RDST_LO      = 6;
  localparam int MEMOP_HI     = 5;
  localparam int MEMOP_LO     = 4;
  localparam int SPOP_HI      = 3;
  localparam int SPOP_LO      = 2;
  localparam int WB           = 1;
  localparam int LDD          = 0;

  // MEM/WB bundle offsets
  localparam int WB_MEMDATA_HI = 36;
  localparam int WB_MEMDATA_LO = 21;
  localparam int WB_ALU_HI     = 20;
  localparam int WB_ALU_LO     = 5;
  localparam int WB_RDST_HI    = 4;
  localparam int WB_RDST_LO    = 2;
  localparam int WB_WB         = 1;
  localparam int WB_MEMTOREG   = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [15:0] alu;
    logic [2:0]  rdst;
    logic        wb;
    logic        mem_to_reg;
    logic        push;
    logic        pop;
  } hold_t;

  function automatic logic [36:0] pack_wb(input logic [15:0] mem_data, input logic [15:0] alu,
                                          input logic [2:0] rdst, input logic wb, input logic mtr);
    logic [36:0] r;
    r = '0;
    r[WB_MEMDATA_HI:WB_MEMDATA_LO] = mem_data;
    r[WB_ALU_HI:WB_ALU_LO]         = alu;
    r[WB_RDST_HI:WB_RDST_LO]       = rdst;
    r[WB_WB]                       = wb;
    r[WB_MEMTOREG]                 = mtr;
    return r;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - data-memory req/ack bus between the memory stage and memory
interface memory_stage_if #(parameter int ADDR_W = 16);
  logic              Mem_Req;
  logic              Mem_We;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [15:0]       Mem_WData;
  logic [15:0]       Mem_RData;
  logic              Mem_Ack;

  modport master(output Mem_Req, Mem_We, Mem_Addr, Mem_WData, input Mem_RData, Mem_Ack);
  modport slave(input Mem_Req, Mem_We, Mem_Addr, Mem_WData, output Mem_RData, Mem_Ack);
endinterface

// File: rtl/memory_stage_sp.sv
// rtl/memory_stage_sp.sv - stack pointer register with increment/decrement
module stack_pointer_reg
  import memory_stage_pkg::*;
#(
  parameter logic [31:0] SP_RESET = 32'h0000_03FF
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        inc,
  input  logic        dec,
  output logic [31:0] SP
);
  logic [31:0] sp_q, sp_d;

  always_comb begin
    sp_d = sp_q;
    if (inc && !dec)      sp_d = sp_q + 32'd1;
    else if (dec && !inc) sp_d = sp_q - 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (Reset) sp_q <= SP_RESET;
    else       sp_q <= sp_d;
  end

  assign SP = sp_q;
endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MEM pipeline stage: data-memory access over req/ack, stack pointer, MEM/WB register
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter logic [31:0] SP_RESET = 32'h0000_03FF,
  parameter int          MAX_WAIT = 16
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic [75:0]    In,
  input  logic           In_Valid,
  output logic           Stall,
  memory_stage_if.master mem,
  output logic [36:0]    Out,
  output logic           Out_Valid,
  output logic [31:0]    SP_Out,
  output logic           Mem_Err
);
  logic [15:0] in_rsrc, in_alu;
  logic [2:0]  in_rdst;
  logic [1:0]  in_memop, in_spop;
  logic        in_wb, in_ldd, in_push, in_pop, in_is_mem, in_we;
  logic [31:0] in_addr_full, sp;
  logic        unused_in;

  assign in_rsrc   = In[RSRC_VAL_HI:RSRC_VAL_LO];
  assign in_alu    = In[ALU_HI:ALU_LO];
  assign in_rdst   = In[RDST_HI:RDST_LO];
  assign in_memop  = In[MEMOP_HI:MEMOP_LO];
  assign in_spop   = In[SPOP_HI:SPOP_LO];
  assign in_wb     = In[WB];
  assign in_ldd    = In[LDD];
  assign unused_in = ^{In[75:RSRC_VAL_HI+1], In[RSRC_ADDR_HI:RSRC_ADDR_LO]};

  assign in_push   = (in_spop == SPOP_PUSH);
  assign in_pop    = (in_spop == SPOP_POP);
  assign in_is_mem = in_push || in_pop || (in_memop == MEMOP_READ) || (in_memop == MEMOP_WRITE);
  assign in_we     = in_push || (!in_pop && (in_memop == MEMOP_WRITE));

  always_comb begin
    if (in_push)     in_addr_full = sp;
    else if (in_pop) in_addr_full = sp + 32'd1;
    else             in_addr_full = {16'h0000, in_alu};
  end

  state_e            state_q, state_d;
  logic              req_q, req_d, we_q, we_d, out_valid_q, out_valid_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d, cnt_q, cnt_d;
  logic [36:0]       out_q, out_d;
  hold_t             hold_q, hold_d;
  logic              timeout, sp_inc, sp_dec;

  assign timeout = (cnt_q == 16'(MAX_WAIT - 1));

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    err_d       = err_q;
    hold_d      = hold_q;
    sp_inc      = 1'b0;
    sp_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (In_Valid && in_is_mem) begin
          state_d = ST_WAIT;
          req_d   = 1'b1;
          we_d    = in_we;
          addr_d  = ADDR_W'(in_addr_full);
          wdata_d = in_rsrc;
          cnt_d   = '0;
          hold_d  = '{alu: in_alu, rdst: in_rdst, wb: in_wb, mem_to_reg: in_ldd || in_pop,
                      push: in_push, pop: in_pop};
        end else if (In_Valid) begin
          out_d       = pack_wb(16'h0000, in_alu, in_rdst, in_wb, in_ldd);
          out_valid_d = 1'b1;
        end
      end
      ST_WAIT: begin
        // ack beats a coincident timeout
        if (mem.Mem_Ack) begin
          state_d     = ST_IDLE;
          req_d       = 1'b0;
          out_d       = pack_wb(we_q ? 16'h0000 : mem.Mem_RData, hold_q.alu, hold_q.rdst,
                                hold_q.wb, hold_q.mem_to_reg);
          out_valid_d = 1'b1;
          sp_dec      = hold_q.push;
          sp_inc      = hold_q.pop;
        end else if (timeout) begin
          state_d     = ST_IDLE;
          req_d       = 1'b0;
          err_d       = 1'b1;
          out_d       = pack_wb(16'h0000, hold_q.alu, hold_q.rdst, hold_q.wb, hold_q.mem_to_reg);
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      hold_q      <= hold_d;
    end
  end

  stack_pointer_reg #(.SP_RESET(SP_RESET)) u_sp (
    .CLK   (CLK),
    .Reset (Reset),
    .inc   (sp_inc),
    .dec   (sp_dec),
    .SP    (sp)
  );

  // Stall releases on the completing edge (ack or timeout) so upstream advances exactly once
  assign Stall = !Reset && (((state_q == ST_IDLE) && In_Valid && in_is_mem) ||
                            ((state_q == ST_WAIT) && !mem.Mem_Ack && !timeout));

  assign mem.Mem_Req   = req_q;
  assign mem.Mem_We    = we_q;
  assign mem.Mem_Addr  = addr_q;
  assign mem.Mem_WData = wdata_q;
  assign Out           = out_q;
  assign Out_Valid     = out_valid_q;
  assign SP_Out        = sp;
  assign Mem_Err       = err_q;
endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed and randomized checks of memory_stage against an instruction-level model
module tb_memory_stage;
  localparam int          ADDR_W   = 16;
  localparam int          MAX_WAIT = 4;
  localparam logic [31:0] SP_RESET = 32'h0000_03FF;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [75:0] In = '0;
  logic        In_Valid = 1'b0;
  logic        Stall;
  logic [36:0] Out;
  logic        Out_Valid;
  logic [31:0] SP_Out;
  logic        Mem_Err;

  memory_stage_if #(.ADDR_W(ADDR_W)) mif ();

  memory_stage #(.ADDR_W(ADDR_W), .SP_RESET(SP_RESET), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .In        (In),
    .In_Valid  (In_Valid),
    .Stall     (Stall),
    .mem       (mif),
    .Out       (Out),
    .Out_Valid (Out_Valid),
    .SP_Out    (SP_Out),
    .Mem_Err   (Mem_Err)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad = 0;
  logic [31:0] m_sp = SP_RESET;
  logic        m_err = 1'b0;
  logic [36:0] m_out = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle(input logic ack);
    In_Valid = 1'b0;
    mif.Mem_Ack = ack;
    @(negedge CLK);
    mif.Mem_Ack = 1'b0;
    check("idle_out_valid", Out_Valid, 1'b0);
    check("idle_out_hold", Out, m_out);
    check("idle_req", mif.Mem_Req, 1'b0);
    check("idle_sp", SP_Out, m_sp);
  endtask

  // ack_at: WAIT cycle index carrying the ack; >= MAX_WAIT means the ack never comes
  task automatic run_instr(input logic [1:0] memop, input logic [1:0] spop, input logic [15:0] alu,
                           input logic [15:0] rsrc, input logic [2:0] rdst, input logic wb,
                           input logic ldd, input int ack_at, input logic [15:0] rd);
    logic        push, pop, is_mem, we, acked;
    logic [31:0] addr32;
    logic [15:0] md;
    push   = (spop == 2'b01);
    pop    = (spop == 2'b10);
    is_mem = push || pop || (memop == 2'b01) || (memop == 2'b10);
    we     = push || (!pop && memop == 2'b10);
    addr32 = push ? m_sp : (pop ? m_sp + 32'd1 : {16'h0000, alu});
    In = {32'($urandom), rsrc, alu, 3'($urandom), rdst, memop, spop, wb, ldd};
    In_Valid = 1'b1;
    #1;
    check("stall_issue", Stall, is_mem);
    @(negedge CLK);
    acked = 1'b0;
    if (!is_mem) begin
      In_Valid = 1'b0;
      m_out = {16'h0000, alu, rdst, wb, ldd};
    end else begin
      for (int k = 0; k < MAX_WAIT; k++) begin
        check("wait_req", mif.Mem_Req, 1'b1);
        check("wait_we", mif.Mem_We, we);
        check("wait_addr", mif.Mem_Addr, addr32[15:0]);
        check("wait_wdata", mif.Mem_WData, rsrc);
        check("wait_out_valid", Out_Valid, 1'b0);
        if (k == ack_at) begin
          mif.Mem_Ack = 1'b1;
          mif.Mem_RData = rd;
          acked = 1'b1;
          #1;
          check("stall_ack", Stall, 1'b0);
        end else if (k < MAX_WAIT - 1) begin
          mif.Mem_RData = 16'($urandom);
          #1;
          check("stall_wait", Stall, 1'b1);
        end
        @(negedge CLK);
        mif.Mem_Ack = 1'b0;
        if (acked) break;
      end
      In_Valid = 1'b0;
      md = (acked && !we) ? rd : 16'h0000;
      if (acked) m_sp = push ? m_sp - 32'd1 : (pop ? m_sp + 32'd1 : m_sp);
      else       m_err = 1'b1;
      m_out = {md, alu, rdst, wb, ldd || pop};
    end
    check("done_out_valid", Out_Valid, 1'b1);
    check("done_out", Out, m_out);
    check("done_req", mif.Mem_Req, 1'b0);
    check("done_sp", SP_Out, m_sp);
    check("done_err", Mem_Err, m_err);
  endtask

  initial begin
    mif.Mem_Ack = 1'b0;
    mif.Mem_RData = '0;
    // a memory instruction presented during reset must not stall
    In = {32'h0, 16'h1111, 16'h0040, 3'd0, 3'd1, 2'b01, 2'b00, 1'b1, 1'b1};
    In_Valid = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_stall", Stall, 1'b0);
    check("rst_out", Out, 37'h0);
    check("rst_out_valid", Out_Valid, 1'b0);
    check("rst_req", mif.Mem_Req, 1'b0);
    check("rst_addr", mif.Mem_Addr, 16'h0);
    check("rst_sp", SP_Out, SP_RESET);
    check("rst_err", Mem_Err, 1'b0);
    Reset = 1'b0;
    In_Valid = 1'b0;
    idle_cycle(1'b0);

    run_instr(2'b00, 2'b00, 16'h1234, 16'h7777, 3'd5, 1'b1, 1'b0, 0, 16'h0);
    idle_cycle(1'b0);
    run_instr(2'b01, 2'b00, 16'h0040, 16'h0000, 3'd2, 1'b1, 1'b1, 2, 16'hBEEF);
    idle_cycle(1'b0);
    run_instr(2'b00, 2'b01, 16'h0000, 16'hA5A5, 3'd0, 1'b0, 1'b0, 0, 16'h0);
    check("push_sp", SP_Out, 32'h0000_03FE);
    run_instr(2'b00, 2'b10, 16'h0000, 16'h0000, 3'd3, 1'b1, 1'b0, 1, 16'hA5A5);
    check("pop_sp", SP_Out, 32'h0000_03FF);
    idle_cycle(1'b0);

    run_instr(2'b10, 2'b00, 16'h0100, 16'hCAFE, 3'd1, 1'b0, 1'b0, MAX_WAIT, 16'h0);
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    check("err_sticky", Mem_Err, 1'b1);

    // reset while a read is pending
    In = {32'h0, 16'h0, 16'h0200, 3'd0, 3'd4, 2'b01, 2'b00, 1'b1, 1'b1};
    In_Valid = 1'b1;
    @(negedge CLK);
    check("rmw_req", mif.Mem_Req, 1'b1);
    Reset = 1'b1;
    #1;
    check("rmw_stall", Stall, 1'b0);
    @(negedge CLK);
    Reset = 1'b0;
    In_Valid = 1'b0;
    m_sp = SP_RESET;
    m_err = 1'b0;
    m_out = '0;
    check("rmw_req_low", mif.Mem_Req, 1'b0);
    check("rmw_out_valid", Out_Valid, 1'b0);
    check("rmw_sp", SP_Out, SP_RESET);
    check("rmw_err", Mem_Err, 1'b0);
    check("rmw_we", mif.Mem_We, 1'b0);
    check("rmw_wdata", mif.Mem_WData, 16'h0);
    idle_cycle(1'b1);
    run_instr(2'b00, 2'b11, 16'h4321, 16'h0, 3'd6, 1'b1, 1'b0, 0, 16'h0);

    run_instr(2'b01, 2'b00, 16'h0077, 16'h0, 3'd7, 1'b1, 1'b1, 0, 16'h5A5A);
    run_instr(2'b11, 2'b00, 16'h0999, 16'h0, 3'd2, 1'b1, 1'b0, 0, 16'h0);
    idle_cycle(1'b0);

    for (int i = 0; i < 40; i++) begin
      run_instr(2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), 3'($urandom),
                1'($urandom), 1'($urandom), int'($urandom_range(0, MAX_WAIT)), 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
    end
    idle_cycle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
